// File: rtl/audio_rate_ctrl.sv
// audio_rate_ctrl: sample-rate scheduler for the USB audio datapath.
//
// Produces the 48 kHz sample strobe shared by the playback and capture
// buffers and gates reads from the host-to-device (playback) buffer. Once per
// USB frame the strobe period is trimmed by +/-ADJ clocks from the playback
// fill level, so drift between the host clock and the local clock never
// drains or overflows the buffer.
//
// Ports:
//   clk          in   system clock (60 MHz)
//   rst          in   synchronous reset, active-high
//   usb_rstn     in   1 = USB connected; 0 forces IDLE
//   sof          in   one-cycle start-of-frame pulse from the USB core
//   fill_level   in   playback buffer occupancy (wptr - rptr)
//   audio_en     out  one-cycle sample strobe (capture-buffer write)
//   out_pop      out  one-cycle playback-buffer read strobe
//   mute         out  1 = playback output held at zero
//   period       out  strobe period currently in use, in clocks
//   locked       out  1 while in RUN
//   underrun_cnt out  saturating count of playback underruns
module audio_rate_ctrl #(
  parameter int NOM_PERIOD = 1250,
  parameter int ADJ        = 1,
  parameter int LVL_W      = 10,
  parameter int TARGET     = 96,
  parameter int HYST       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             usb_rstn,
  input  logic             sof,
  input  logic [LVL_W-1:0] fill_level,
  output logic             audio_en,
  output logic             out_pop,
  output logic             mute,
  output logic [10:0]      period,
  output logic             locked,
  output logic [7:0]       underrun_cnt
);

  localparam int PER_W = 11;

  localparam logic [PER_W-1:0] NOM_P  = PER_W'(NOM_PERIOD);
  localparam logic [PER_W-1:0] FAST_P = PER_W'(NOM_PERIOD - ADJ);
  localparam logic [PER_W-1:0] SLOW_P = PER_W'(NOM_PERIOD + ADJ);
  localparam logic [LVL_W-1:0] TGT_L  = LVL_W'(TARGET);
  localparam logic [LVL_W-1:0] HI_L   = LVL_W'(TARGET + HYST);
  localparam logic [LVL_W-1:0] LO_L   = LVL_W'(TARGET - HYST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PER_W-1:0] cnt;
  logic [PER_W-1:0] period_cur;
  logic [PER_W-1:0] period_next;
  logic             strobe_p0;
  logic [7:0]       underrun_q;
  logic             wrap;
  logic             underrun;

  // Saturating increment for the underrun counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    if (v == 8'hFF) return v;
    return v + 8'd1;
  endfunction

  // Period selection from fill level: a fuller buffer is drained faster.
  function automatic logic [PER_W-1:0] trim_period(input logic [LVL_W-1:0] lvl);
    if (lvl > HI_L) return FAST_P;
    if (lvl < LO_L) return SLOW_P;
    return NOM_P;
  endfunction

  assign wrap     = (cnt == period_cur - 11'd1);
  // An underrun is a strobe in RUN with nothing to read.
  assign underrun = (state == RUN) && strobe_p0 && (fill_level == '0);

  always_comb begin
    state_nxt = state;
    if (!usb_rstn) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = PRIME;
        PRIME:   if (sof && (fill_level >= TGT_L)) state_nxt = RUN;
        RUN:     if (underrun) state_nxt = PRIME;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Strobe counter and period bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      period_cur  <= NOM_P;
      period_next <= NOM_P;
      strobe_p0   <= 1'b0;
      underrun_q  <= '0;
    end else begin
      // Survives disconnects; only rst clears the history.
      if (underrun) underrun_q <= sat_inc(underrun_q);

      if (!usb_rstn || state == IDLE) begin
        cnt         <= '0;
        strobe_p0   <= 1'b0;
        period_cur  <= NOM_P;
        period_next <= NOM_P;
      end else begin
        if (wrap) begin
          cnt        <= '0;
          strobe_p0  <= 1'b1;
          // Old period_next: a same-cycle sof only affects the wrap after.
          period_cur <= period_next;
        end else begin
          cnt       <= cnt + 11'd1;
          strobe_p0 <= 1'b0;
        end

        if (state == PRIME || underrun) period_next <= NOM_P;
        else if (sof)                   period_next <= trim_period(fill_level);
      end
    end
  end

  assign audio_en     = strobe_p0;
  assign out_pop      = underrun ? 1'b0 : (strobe_p0 && (state == RUN));
  assign mute         = (state != RUN);
  assign locked       = (state == RUN);
  assign period       = period_cur;
  assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_audio_rate_ctrl.sv
// Testbench for audio_rate_ctrl. The stimulus process queues the expected
// state of every sample strobe; a monitor pops and compares on each strobe.
// A second, short-period instance exercises underrun counter saturation.
module tb_audio_rate_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, usb_rstn, sof;
  logic [9:0] fill_level;
  logic       audio_en, out_pop, mute, locked;
  logic [10:0] period;
  logic [7:0] underrun_cnt;

  logic       f_rst, f_usb_rstn, f_sof;
  logic [9:0] f_fill_level;
  logic       f_audio_en, f_out_pop, f_mute, f_locked;
  logic [10:0] f_period;
  logic [7:0] f_underrun_cnt;

  audio_rate_ctrl dut (
    .clk(clk), .rst(rst), .usb_rstn(usb_rstn), .sof(sof),
    .fill_level(fill_level), .audio_en(audio_en), .out_pop(out_pop),
    .mute(mute), .period(period), .locked(locked),
    .underrun_cnt(underrun_cnt)
  );

  audio_rate_ctrl #(.NOM_PERIOD(8)) dut_fast (
    .clk(clk), .rst(f_rst), .usb_rstn(f_usb_rstn), .sof(f_sof),
    .fill_level(f_fill_level), .audio_en(f_audio_en), .out_pop(f_out_pop),
    .mute(f_mute), .period(f_period), .locked(f_locked),
    .underrun_cnt(f_underrun_cnt)
  );

  typedef struct {
    logic        pop;
    logic [10:0] per;
    logic        mute;
    logic        lock;
    logic [7:0]  uc;
    int          gap;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input logic pop, input logic [10:0] per, input logic m,
                      input logic l, input logic [7:0] uc, input int gap);
    exp_t e;
    e.pop = pop; e.per = per; e.mute = m; e.lock = l; e.uc = uc; e.gap = gap;
    q.push_back(e);
  endtask

  // Monitor: compare every strobe of the main instance against the queue.
  int   mon_cyc  = 0;
  int   mon_last = 0;
  exp_t mon_e;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mon_cyc++;
      if (audio_en === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: strobe at cycle %0d, none required", mon_cyc);
        end else begin
          mon_e = q.pop_front();
          check("strobe_out_pop", out_pop, mon_e.pop);
          check("strobe_period", period, mon_e.per);
          check("strobe_mute", mute, mon_e.mute);
          check("strobe_locked", locked, mon_e.lock);
          check("strobe_underrun_cnt", underrun_cnt, mon_e.uc);
          if (mon_e.gap != 0) check("strobe_spacing", mon_cyc - mon_last, mon_e.gap);
        end
        mon_last = mon_cyc;
      end
    end
  end

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (audio_en !== 1'b1 && n < 2000);
    if (audio_en !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL strobe_timeout: no audio_en within %0d cycles", n);
    end
  endtask

  task automatic f_wait_strobe();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (f_audio_en !== 1'b1 && n < 20);
    if (f_audio_en !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL fast_strobe_timeout: no audio_en within %0d cycles", n);
    end
  endtask

  // Called at a negedge; leaves sof low at the following negedge.
  task automatic sof_pulse(input logic [9:0] f);
    fill_level = f;
    sof = 1'b1;
    @(negedge clk);
    sof = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_audio_en"}, audio_en, 0);
    check({tag, "_out_pop"}, out_pop, 0);
    check({tag, "_mute"}, mute, 1);
    check({tag, "_period"}, period, 1250);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_underrun_cnt"}, underrun_cnt, 0);
  endtask

  int trim_fill [6] = '{120, 70, 100, 112, 79, 80};
  int trim_per  [6] = '{1249, 1251, 1250, 1250, 1251, 1250};

  initial begin
    int n;
    int prev;
    rst = 1'b1; usb_rstn = 1'b0; sof = 1'b0; fill_level = '0;
    f_rst = 1'b1; f_usb_rstn = 1'b0; f_sof = 1'b0; f_fill_level = '0;

    // Reset and connect
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0; f_rst = 1'b0;
    repeat (7) @(negedge clk);
    push(0, 1250, 1, 0, 0, 0);
    usb_rstn = 1'b1;
    wait_strobe(n);
    check("first_strobe_latency", n, 1251);

    // Prime to lock
    @(negedge clk);
    sof_pulse(95);
    check("prime_below_target_locked", locked, 0);
    check("prime_below_target_mute", mute, 1);
    sof_pulse(96);
    check("lock_locked", locked, 1);
    check("lock_mute", mute, 0);
    push(1, 1250, 0, 1, 0, 1250);
    wait_strobe(n);

    // Trim up, down, and at the dead-band edges
    prev = 1250;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sof_pulse(10'(trim_fill[i]));
      push(1, 11'(trim_per[i]), 0, 1, 0, prev);
      prev = trim_per[i];
      wait_strobe(n);
    end

    // Sof on the wrap cycle: this wrap keeps 1250, the next one takes 1249
    repeat (1249) @(negedge clk);
    push(1, 1250, 0, 1, 0, 1250);
    fill_level = 10'd120;
    sof = 1'b1;
    wait_strobe(n);
    sof = 1'b0;
    check("wrap_sof_alignment", n, 1);
    push(1, 1249, 0, 1, 0, 1250);
    wait_strobe(n);
    @(negedge clk);
    sof_pulse(100);
    push(1, 1250, 0, 1, 0, 1249);
    wait_strobe(n);

    // Underrun while running on a trimmed period
    @(negedge clk);
    sof_pulse(120);
    push(1, 1249, 0, 1, 0, 1250);
    wait_strobe(n);
    @(negedge clk);
    fill_level = '0;
    push(0, 1249, 0, 1, 0, 1249);
    wait_strobe(n);
    @(negedge clk);
    check("underrun_cnt_after", underrun_cnt, 1);
    check("underrun_mute", mute, 1);
    check("underrun_locked", locked, 0);
    push(0, 1250, 1, 0, 1, 1249);
    wait_strobe(n);

    // Disconnect at cnt=600 in RUN
    @(negedge clk);
    sof_pulse(96);
    push(1, 1250, 0, 1, 1, 1250);
    wait_strobe(n);
    repeat (600) @(negedge clk);
    usb_rstn = 1'b0;
    @(negedge clk);
    check("disc_audio_en", audio_en, 0);
    check("disc_mute", mute, 1);
    check("disc_locked", locked, 0);
    check("disc_period", period, 1250);
    check("disc_underrun_kept", underrun_cnt, 1);
    repeat (1300) @(negedge clk);
    push(0, 1250, 1, 0, 1, 0);
    usb_rstn = 1'b1;
    wait_strobe(n);
    check("reconnect_latency", n, 1251);

    // rst in the middle of RUN
    @(negedge clk);
    sof_pulse(96);
    @(negedge clk);
    sof_pulse(120);
    push(1, 1249, 0, 1, 1, 1250);
    wait_strobe(n);
    repeat (300) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrun_rst");
    rst = 1'b0;
    usb_rstn = 1'b0;
    @(negedge clk);

    // Saturation on the short-period instance: 300 underruns
    f_usb_rstn = 1'b1;
    for (int i = 0; i <= 300; i++) begin
      f_wait_strobe();
      @(negedge clk);
      f_fill_level = 10'd96;
      f_sof = 1'b1;
      @(negedge clk);
      f_sof = 1'b0;
      f_fill_level = '0;
      if (i == 1)   check("sat_cnt_1", f_underrun_cnt, 1);
      if (i == 10)  check("sat_cnt_10", f_underrun_cnt, 10);
      if (i == 255) check("sat_cnt_255", f_underrun_cnt, 255);
    end
    check("sat_cnt_final", f_underrun_cnt, 255);

    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_rate_ctrl.md
Name: audio_rate_ctrl

Overview:
- Sample-rate scheduler for the USB audio datapath.
- Generates the 48 kHz sample strobe shared by the playback and capture buffers. It also gates reads from the host-to-device (playback) buffer.
- Trims the strobe period by ±ADJ clocks once per USB frame, based on playback-buffer fill level, so host/local clock drift never empties or overflows the buffer.
- Sits between the USB core (sof, connect state) and the audio buffers; replaces the free-running 1250-count divider.

Parameters:
- NOM_PERIOD, 1250: nominal clocks per sample (60 MHz / 48 kHz).
- ADJ, 1: period trim step in clocks.
- LVL_W, 10: width of fill_level; buffer depth is 2^(LVL_W-1) = 512 entries.
- TARGET, 96: desired fill, in samples (2 USB frames).
- HYST, 16: dead band around TARGET.

Ports:
- clk  in  1  system clock, 60 MHz.
- rst  in  1  synchronous reset, active-high.
- usb_rstn  in  1  1 = USB connected. 0 forces IDLE.
- sof  in  1  one-cycle start-of-frame pulse from the USB core.
- fill_level  in  LVL_W  playback buffer occupancy (wptr - rptr), valid every cycle.
- audio_en  out  1  one-cycle sample strobe. Drives capture-buffer writes.
- out_pop  out  1  one-cycle playback-buffer read strobe.
- mute  out  1  1 = playback output must be held at zero.
- period  out  11  period currently in use.
- locked  out  1  1 in RUN state.
- underrun_cnt  out  8  saturating underrun count.

Behaviour:
- Reset (rst=1, synchronous) values:
  - all outputs 0, except period = NOM_PERIOD and mute = 1;
  - cnt = 0, period_next = NOM_PERIOD, state = IDLE.
- Reset takes effect on the next edge, even mid-period or mid-frame.
- Counter:
  - cnt increments each clock while not IDLE.
  - When cnt == period-1, on the next edge: cnt <= 0, audio_en <= 1 for exactly one cycle, and period <= period_next.
  - The period changes only at this wrap, never mid-sample.
  - First audio_en after entering PRIME is asserted NOM_PERIOD edges later.
- States:
  - IDLE: held while usb_rstn=0 (checked every cycle, overrides every other state). cnt = 0, audio_en = out_pop = 0, mute = 1, period = period_next = NOM_PERIOD. Moves to PRIME on the first cycle with usb_rstn=1.
  - PRIME: strobe runs with period_next forced to NOM_PERIOD; out_pop = 0; mute = 1. On a sof cycle with fill_level >= TARGET, moves to RUN: mute <= 0, locked <= 1.
  - RUN: out_pop = audio_en, except when fill_level == 0 in the strobe cycle. That is an underrun: out_pop = 0, underrun_cnt++ (saturates at 255), next state PRIME, mute <= 1, locked <= 0, period_next <= NOM_PERIOD.
- Trim in RUN, evaluated on each sof using that cycle's fill_level:
  - fill_level > TARGET+HYST: period_next <= NOM_PERIOD-ADJ (consume faster).
  - fill_level < TARGET-HYST: period_next <= NOM_PERIOD+ADJ.
  - otherwise: period_next <= NOM_PERIOD.
  - Comparisons are unsigned, at LVL_W bits.
- Simultaneous sof and wrap in the same cycle: the wrap loads the period_next value from before this cycle's sof update. The new value applies at the following wrap.
- Simultaneous sof (PRIME→RUN) and strobe in the same cycle: out_pop stays 0 for that strobe. Popping starts from the next strobe.
- underrun_cnt is cleared only by rst; it is not cleared by IDLE.
- audio_en keeps running in PRIME and RUN regardless of mute, so capture is never interrupted while connected.

Test Plan:
- Reset and connect: rst 2 cycles, then usb_rstn=1 at cycle 10. Required: audio_en pulses every 1250 clks, period=1250, mute=1, out_pop never asserted, locked=0.
- Prime to lock: fill_level=95 at one sof, then 96 at the next. Required: still PRIME after the first; locked=1 and mute=0 after the second; the next audio_en has out_pop=1.
- Trim up and down: in RUN, sof with fill=120 → the period after the next wrap is 1249 (strobe spacing 1249). sof with fill=70 → 1251. sof with fill=100 → 1250.
- Sof coinciding with wrap: period_next=1250, sof with fill=120 on the wrap cycle. Required: that period is 1250; the following period is 1249.
- Underrun: in RUN, fill_level=0 at a strobe. Required: out_pop=0, underrun_cnt 0→1, mute=1, locked=0, period returns to 1250. 300 forced underruns leave underrun_cnt=255.
- Disconnect mid-period: usb_rstn=0 at cnt=600 in RUN. Required: the next cycle is IDLE with cnt=0, no further strobes, mute=1, and underrun_cnt is retained. Also drive rst=1 mid-RUN: all outputs reach their reset values on the next edge.
